fp_mul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier for the vector datapath lanes. It adds several things to the single-cycle multiplier generation:
- configurable exponent and mantissa widths
- valid/ready flow control with backpressure
- round-to-nearest-even
- special-value handling
- exception flags

Three-stage pipeline, one result per cycle when not stalled.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_mant_mul.sv | 13 +
 rtl/fp_mul_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point datapath:
// format helpers, operand classes, flag positions and the canonical quiet NaN.
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    function automatic int fpWidth(input int expW, input int manW);
        return 1 + expW + manW;
    endfunction

    function automatic int fpBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    // Positive sign, all-ones exponent, only the mantissa MSB set; callers slice to their width.
    function automatic logic [63:0] fpQnan(input int expW, input int manW);
        logic [63:0] r;
        r = ((64'd1 << expW) - 64'd1) << manW;
        r = r | (64'd1 << (manW - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_mant_mul.sv
// Combinational unsigned significand multiplier, kept separate so a
// Dadda-tree implementation can replace it without touching the pipeline.
module fp_mant_mul #(
    parameter int N = 24
) (
    input  logic [N-1:0]   x_i,
    input  logic [N-1:0]   y_i,
    output logic [2*N-1:0] p_o
);

    assign p_o = {{N{1'b0}}, x_i} * {{N{1'b0}}, y_i};

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: operand register, then classify,
// multiply and normalise/round/pack stages, all advanced by one global enable.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = fpWidth(EXP_W, MAN_W),
    localparam int BIAS = fpBias(EXP_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [3:0]   flags
);

    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_SAT   = EW'((1 << EXP_W) - 1);
    localparam logic [63:0]          QNAN_WIDE = fpQnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN_Z    = QNAN_WIDE[W-1:0];

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return ZERO;
        if (e != '1) return NORM;
        if (m == '0) return INF;
        return m[MAN_W-1] ? QNAN : SNAN;
    endfunction

    logic en;
    logic outValid_q;
    logic [W-1:0] z_q;
    logic [3:0] flags_q;

    // A stalled output freezes every stage, so bubbles are held in place too.
    assign en        = !outValid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = outValid_q;
    assign z         = z_q;
    assign flags     = flags_q;

    logic opValid_q;
    logic [W-1:0] opA_q, opB_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opValid_q <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
        end else if (en) begin
            opValid_q <= in_valid;
            opA_q     <= a;
            opB_q     <= b;
        end
    end

    logic [EXP_W-1:0] expA, expB;
    fp_class_t clsA, clsB;
    logic sign1, anyNan, anySnan, infZero, special1;
    logic signed [EW-1:0] exp1;
    logic [W-1:0] specZ1;
    logic [3:0] specF1;

    assign expA  = opA_q[W-2 -: EXP_W];
    assign expB  = opB_q[W-2 -: EXP_W];
    assign clsA  = classify(expA, opA_q[MAN_W-1:0]);
    assign clsB  = classify(expB, opB_q[MAN_W-1:0]);
    assign sign1 = opA_q[W-1] ^ opB_q[W-1];
    assign exp1  = EW'(expA) + EW'(expB) - EW'(BIAS);

    // Special operands are resolved here and ride the pipe to keep latency uniform.
    always_comb begin
        anyNan   = (clsA == QNAN) || (clsA == SNAN) || (clsB == QNAN) || (clsB == SNAN);
        anySnan  = (clsA == SNAN) || (clsB == SNAN);
        infZero  = ((clsA == INF) && (clsB == ZERO)) || ((clsA == ZERO) && (clsB == INF));
        special1 = 1'b1;
        specZ1   = '0;
        specF1   = '0;
        if (anyNan || infZero) begin
            specZ1          = QNAN_Z;
            specF1[FLG_INV] = anySnan || infZero;
        end else if ((clsA == INF) || (clsB == INF)) begin
            specZ1 = {sign1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((clsA == ZERO) || (clsB == ZERO)) begin
            specZ1 = {sign1, {(W-1){1'b0}}};
        end else begin
            special1 = 1'b0;
        end
    end

    logic s1Valid_q, s1Sign_q, s1Special_q;
    logic signed [EW-1:0] s1Exp_q;
    logic [SW-1:0] s1ManA_q, s1ManB_q;
    logic [W-1:0] s1SpecZ_q;
    logic [3:0] s1SpecF_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            s1Sign_q    <= 1'b0;
            s1Special_q <= 1'b0;
            s1Exp_q     <= '0;
            s1ManA_q    <= '0;
            s1ManB_q    <= '0;
            s1SpecZ_q   <= '0;
            s1SpecF_q   <= '0;
        end else if (en) begin
            s1Valid_q   <= opValid_q;
            s1Sign_q    <= sign1;
            s1Special_q <= special1;
            s1Exp_q     <= exp1;
            s1ManA_q    <= {1'b1, opA_q[MAN_W-1:0]};
            s1ManB_q    <= {1'b1, opB_q[MAN_W-1:0]};
            s1SpecZ_q   <= specZ1;
            s1SpecF_q   <= specF1;
        end
    end

    logic [PW-1:0] prod2;

    fp_mant_mul #(.N(SW)) uMantMul (
        .x_i(s1ManA_q),
        .y_i(s1ManB_q),
        .p_o(prod2)
    );

    logic s2Valid_q, s2Sign_q, s2Special_q;
    logic signed [EW-1:0] s2Exp_q;
    logic [PW-1:0] s2Prod_q;
    logic [W-1:0] s2SpecZ_q;
    logic [3:0] s2SpecF_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q   <= 1'b0;
            s2Sign_q    <= 1'b0;
            s2Special_q <= 1'b0;
            s2Exp_q     <= '0;
            s2Prod_q    <= '0;
            s2SpecZ_q   <= '0;
            s2SpecF_q   <= '0;
        end else if (en) begin
            s2Valid_q   <= s1Valid_q;
            s2Sign_q    <= s1Sign_q;
            s2Special_q <= s1Special_q;
            s2Exp_q     <= s1Exp_q;
            s2Prod_q    <= prod2;
            s2SpecZ_q   <= s1SpecZ_q;
            s2SpecF_q   <= s1SpecF_q;
        end
    end

    logic [PW-2:0] prodN;
    logic signed [EW-1:0] expN, expR;
    logic [MAN_W-1:0] manT, manF;
    logic [MAN_W:0] manR;
    logic guardBit, stickyBit, roundUp;
    logic [W-1:0] z_d;
    logic [3:0] flags_d;

    // prodN drops the leading one, so its top MAN_W bits are the kept mantissa.
    always_comb begin
        prodN     = s2Prod_q[PW-1] ? s2Prod_q[PW-2:0] : {s2Prod_q[PW-3:0], 1'b0};
        expN      = s2Exp_q + EW'(s2Prod_q[PW-1]);
        manT      = prodN[PW-2 -: MAN_W];
        guardBit  = prodN[MAN_W];
        stickyBit = |prodN[MAN_W-1:0];
        roundUp   = guardBit && (stickyBit || manT[0]);
        manR      = {1'b0, manT} + (MAN_W+1)'(roundUp);
        expR      = expN + EW'(manR[MAN_W]);
        manF      = manR[MAN_W] ? '0 : manR[MAN_W-1:0];
        z_d       = {s2Sign_q, expR[EXP_W-1:0], manF};
        flags_d   = '0;
        flags_d[FLG_NX] = guardBit || stickyBit;
        if (s2Special_q) begin
            z_d     = s2SpecZ_q;
            flags_d = s2SpecF_q;
        end else if (expR >= EXP_SAT) begin
            z_d              = {s2Sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d          = '0;
            flags_d[FLG_OVF] = 1'b1;
            flags_d[FLG_NX]  = 1'b1;
        end else if (expR[EW-1] || (expR == '0)) begin
            z_d              = {s2Sign_q, {(W-1){1'b0}}};
            flags_d          = '0;
            flags_d[FLG_UNF] = 1'b1;
            flags_d[FLG_NX]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            z_q        <= '0;
            flags_q    <= '0;
        end else if (en) begin
            outValid_q <= s2Valid_q;
            z_q        <= z_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe: single precision plus a half-precision
// instance, covering latency, rounding, specials, backpressure and async reset.
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst;

    logic inValid, inReady, outValid, outReady;
    logic [31:0] opA, opB, zOut;
    logic [3:0] flagsOut;

    logic hInValid, hInReady, hOutValid, hOutReady;
    logic [15:0] hA, hB, hZ;
    logic [3:0] hFlags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk),
        .rst(rst),
        .in_valid(inValid),
        .in_ready(inReady),
        .a(opA),
        .b(opB),
        .out_valid(outValid),
        .out_ready(outReady),
        .z(zOut),
        .flags(flagsOut)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dutHalf (
        .clk(clk),
        .rst(rst),
        .in_valid(hInValid),
        .in_ready(hInReady),
        .a(hA),
        .b(hB),
        .out_valid(hOutValid),
        .out_ready(hOutReady),
        .z(hZ),
        .flags(hFlags)
    );

    logic [31:0] vecA [13] = '{32'h3FC00000, 32'h3F800001, 32'h3F800000, 32'h3F800001, 32'h3F800003,
                               32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7FA00000, 32'h7FC00001,
                               32'h7F800000, 32'h00000000, 32'h00000001};
    logic [31:0] vecB [13] = '{32'h40000000, 32'h3F800001, 32'hBF800000, 32'h3FC00000, 32'h3FC00000,
                               32'h7F000000, 32'h3F000000, 32'h00000000, 32'h3F800000, 32'h40000000,
                               32'hC0000000, 32'hBFC00000, 32'h3F800000};
    logic [31:0] vecZ [13] = '{32'h40400000, 32'h3F800002, 32'hBF800000, 32'h3FC00002, 32'h3FC00004,
                               32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                               32'hFF800000, 32'h80000000, 32'h00000000};
    logic [3:0]  vecF [13] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h5, 4'h3, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

    logic [15:0] hVecA [3] = '{16'h3E00, 16'h7800, 16'h3C01};
    logic [15:0] hVecB [3] = '{16'h4000, 16'h7800, 16'h3C01};
    logic [15:0] hVecZ [3] = '{16'h4200, 16'h7C00, 16'h3C02};
    logic [3:0]  hVecF [3] = '{4'h0, 4'h5, 4'h1};

    int streamIdx [6] = '{0, 1, 2, 3, 5, 7};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One op on the single-precision DUT with out_ready high; checks latency, z and flags.
    task automatic applyStimulus(input int idx);
        int lat;
        @(negedge clk);
        inValid = 1'b1;
        opA     = vecA[idx];
        opB     = vecB[idx];
        @(negedge clk);
        inValid = 1'b0;
        lat     = 0;
        while (!outValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("v%0d_latency", idx), lat, 3);
        checkOutput($sformatf("v%0d_z", idx), zOut, vecZ[idx]);
        checkOutput($sformatf("v%0d_flags", idx), {28'd0, flagsOut}, {28'd0, vecF[idx]});
    endtask

    task automatic applyHalf(input int idx);
        int lat;
        @(negedge clk);
        hInValid = 1'b1;
        hA       = hVecA[idx];
        hB       = hVecB[idx];
        @(negedge clk);
        hInValid = 1'b0;
        lat      = 0;
        while (!hOutValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("h%0d_latency", idx), lat, 3);
        checkOutput($sformatf("h%0d_z", idx), {16'd0, hZ}, {16'd0, hVecZ[idx]});
        checkOutput($sformatf("h%0d_flags", idx), {28'd0, hFlags}, {28'd0, hVecF[idx]});
    endtask

    // Six back-to-back ops; the first visible result is held for five cycles.
    task automatic runStream();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stallLeft = 5;
        int extra = 0;
        outReady = 1'b1;
        while (got < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (outValid) begin
                checkOutput($sformatf("stream%0d_z", got), zOut, vecZ[streamIdx[got]]);
                checkOutput($sformatf("stream%0d_flags", got), {28'd0, flagsOut},
                            {28'd0, vecF[streamIdx[got]]});
            end
            outReady = !(outValid && stallLeft > 0);
            if (outValid && stallLeft > 0) stallLeft--;
            if (sent < 6) begin
                inValid = 1'b1;
                opA     = vecA[streamIdx[sent]];
                opB     = vecB[streamIdx[sent]];
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (!outReady) checkOutput("stall_in_ready", {31'd0, inReady}, 32'd0);
            if (outValid && outReady) got++;
            if (inValid && inReady) sent++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("stream_count", got, 6);
        checkOutput("stall_cycles_used", stallLeft, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (outValid) extra++;
        end
        checkOutput("stream_no_dup", extra, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stale;
        int waitCyc;
        rst       = 1'b1;
        inValid   = 1'b0;
        outReady  = 1'b0;
        opA       = '0;
        opB       = '0;
        hInValid  = 1'b0;
        hOutReady = 1'b1;
        hA        = '0;
        hB        = '0;
        #1;
        checkOutput("reset_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset_z", zOut, 32'd0);
        checkOutput("reset_flags", {28'd0, flagsOut}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, inReady}, 32'd1);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        outReady = 1'b1;

        $display("[TB] directed single-precision vectors");
        for (int i = 0; i < 13; i++) applyStimulus(i);

        $display("[TB] half-precision vectors");
        for (int i = 0; i < 3; i++) applyHalf(i);

        $display("[TB] backpressure stream");
        runStream();

        $display("[TB] reset mid-stream");
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b1;
        opA      = vecA[0];
        opB      = vecB[0];
        @(negedge clk);
        opA = vecA[1];
        opB = vecB[1];
        @(negedge clk);
        inValid = 1'b0;
        waitCyc = 0;
        while (!outValid && waitCyc < 10) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("pre_reset_z", zOut, vecZ[0]);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("async_reset_z", zOut, 32'd0);
        checkOutput("async_reset_flags", {28'd0, flagsOut}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        outReady = 1'b1;
        stale    = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (outValid) stale++;
        end
        checkOutput("post_reset_stale", stale, 0);
        applyStimulus(3);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
